// File: rtl/spi_tick_master_if.sv
// System-side byte interface of spi_tick_master: request/accept handshake plus receive strobe.
// master = command logic driving requests, slave = the SPI engine.
// No storage here; timing is owned by the modules on either side.
interface spi_tick_master_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, rx_data, rx_valid, busy
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, rx_data, rx_valid, busy
   );
endinterface

// File: rtl/spi_tick_master.sv
// Single-frame SPI mode-0 master paced by a synchronised divider tick; optional receive path under SPI_RX_EN.
// Latency: accept to cs_n rise = CS_SETUP + 2*DATA_W + 1 ticks, then one GAP tick before the next accept.
// Backpressure: tx_ready is high only in IDLE; requests while busy are dropped, not queued.
module spi_tick_master #(
   parameter int DATA_W   = 8,
   parameter int CS_SETUP = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clk_div_i,
   spi_tick_master_if.slave   bus,
   output logic               sclk,
   output logic               cs_n,
   output logic               mosi,
   input  logic               miso
);
   localparam int CNT_W = $clog2(2*DATA_W+1);
   localparam int SET_W = $clog2(CS_SETUP+1);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

   state_t              state, state_d;
   logic [2:0]          div_sync;
   logic                tick;
   logic                sclk_d, cs_n_d, mosi_d, rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]   tx_sh, tx_sh_d;
   logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
   logic [SET_W-1:0]    setup_cnt, setup_cnt_d;
`ifdef SPI_RX_EN
   logic [DATA_W-1:0]   rx_sh, rx_sh_d, rx_data_q, rx_data_d;
`else
   logic                unused_miso;
   assign unused_miso = miso;
`endif

   // Two flops bring the divider level into clk, the third provides the previous value for edge detect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) div_sync <= '0;
      else        div_sync <= {div_sync[1:0], clk_div_i};
   end

   assign tick = div_sync[1] & ~div_sync[2];

   // State and datapath registers; all next values come from the combinational block below.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sclk       <= 1'b0;
         cs_n       <= 1'b1;
         mosi       <= 1'b0;
         tx_sh      <= '0;
         bit_cnt    <= '0;
         setup_cnt  <= '0;
         rx_valid_q <= 1'b0;
`ifdef SPI_RX_EN
         rx_sh      <= '0;
         rx_data_q  <= '0;
`endif
      end else begin
         state      <= state_d;
         sclk       <= sclk_d;
         cs_n       <= cs_n_d;
         mosi       <= mosi_d;
         tx_sh      <= tx_sh_d;
         bit_cnt    <= bit_cnt_d;
         setup_cnt  <= setup_cnt_d;
         rx_valid_q <= rx_valid_d;
`ifdef SPI_RX_EN
         rx_sh      <= rx_sh_d;
         rx_data_q  <= rx_data_d;
`endif
      end
   end

   // Frame sequencing: every SCLK/CS_n change happens on a tick, except the CS_n fall at accept.
   always_comb begin
      state_d     = state;
      sclk_d      = sclk;
      cs_n_d      = cs_n;
      mosi_d      = mosi;
      tx_sh_d     = tx_sh;
      bit_cnt_d   = bit_cnt;
      setup_cnt_d = setup_cnt;
      rx_valid_d  = 1'b0;
`ifdef SPI_RX_EN
      rx_sh_d     = rx_sh;
      rx_data_d   = rx_data_q;
`endif
      case (state)
         IDLE: begin
            // A tick coinciding with accept is deliberately not consumed here.
            if (bus.tx_valid) begin
               tx_sh_d     = bus.tx_data;
               cs_n_d      = 1'b0;
               mosi_d      = bus.tx_data[DATA_W-1];
               setup_cnt_d = SET_W'(CS_SETUP);
               state_d     = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               setup_cnt_d = setup_cnt - SET_W'(1);
               if (setup_cnt == SET_W'(1)) begin
                  bit_cnt_d = '0;
                  state_d   = XFER;
               end
            end
         end
         XFER: begin
            if (tick) begin
               sclk_d    = ~sclk;
               bit_cnt_d = bit_cnt + CNT_W'(1);
               if (!sclk) begin
`ifdef SPI_RX_EN
                  rx_sh_d = {rx_sh[DATA_W-2:0], miso};
`endif
               end else begin
                  tx_sh_d = {tx_sh[DATA_W-2:0], 1'b0};
                  mosi_d  = tx_sh[DATA_W-2];
               end
               if (bit_cnt == CNT_W'(2*DATA_W-1)) state_d = HOLD;
            end
         end
         HOLD: begin
            if (tick) begin
               cs_n_d     = 1'b1;
               mosi_d     = 1'b0;
               rx_valid_d = 1'b1;
`ifdef SPI_RX_EN
               rx_data_d  = rx_sh;
`endif
               state_d    = GAP;
            end
         end
         GAP: begin
            if (tick) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tx_ready = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.rx_valid = rx_valid_q;
`ifdef SPI_RX_EN
   assign bus.rx_data  = rx_data_q;
`else
   assign bus.rx_data  = '0;
`endif
endmodule

// File: tb/tb_spi_tick_master.sv
// Bench for spi_tick_master: directed scenarios plus random frames checked against a bit-level SPI model.
// Divider is a free-running 16-clk counter (50 MHz / 2^4) that can be frozen to stall ticks.
// Receive expectations depend on whether SPI_RX_EN is defined for the build.
module tb_spi_tick_master;
`ifdef SPI_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] div_cnt = '0;
   logic       div_stall = 1'b0;
   logic       clk_div_i;
   logic       sclk, cs_n, mosi, miso;
   logic       miso_r = 1'b0;
   int         miso_sel = 0;

   int total = 0;
   int bad = 0;

   spi_tick_master_if #(.DATA_W(8)) bus ();

   spi_tick_master #(.DATA_W(8), .CS_SETUP(1)) dut (
      .clk(clk), .rst_n(rst_n), .clk_div_i(clk_div_i), .bus(bus),
      .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
   );

   always #10 clk = ~clk;

   always @(posedge clk) if (!div_stall) div_cnt <= div_cnt + 4'd1;
   assign clk_div_i = div_cnt[3];

   assign miso = (miso_sel == 0) ? mosi : (miso_sel == 2) ? 1'b1 : miso_r;

   // Pin-level observer
   int   rises = 0, cs_low = 0, hi_run = 0, last_gap = 0, rxv_cnt = 0;
   bit   mosi_q[$];
   bit   miso_q[$];
   logic [7:0] rx_log[$];
   logic prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (sclk && !prev_sclk) begin
         rises++;
         mosi_q.push_back(mosi);
         miso_q.push_back(miso);
      end
      if (!sclk && prev_sclk) miso_r = 1'($urandom);
      if (!cs_n) begin
         cs_low++;
         if (hi_run != 0) last_gap = hi_run;
         hi_run = 0;
      end else begin
         hi_run++;
      end
      if (bus.rx_valid) begin
         rxv_cnt++;
         rx_log.push_back(bus.rx_data);
      end
      prev_sclk = sclk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pack(input bit q[$], input int off);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         r = {r[6:0], (off + i < q.size()) ? q[off+i] : 1'b0};
      return r;
   endfunction

   function automatic logic cond(input int sel, input int val);
      case (sel)
         0:       return bus.busy == val[0];
         1:       return bus.tx_ready == val[0];
         default: return rises >= val;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int val, input int lim, input string tag);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(posedge clk); #1;
         ok = cond(sel, val);
      end
      check(tag, ok, 1);
   endtask

   task automatic clear_obs();
      rises = 0; cs_low = 0; rxv_cnt = 0;
      mosi_q.delete(); miso_q.delete(); rx_log.delete();
   endtask

   // mode 0: plain, 1: competing request mid-frame, 2: divider stall mid-frame
   task automatic run_frame(input logic [7:0] d, input int sel, input int mode);
      logic s_sclk, s_cs, s_mosi;
      logic [7:0] exp_rx;
      miso_sel = sel;
      @(posedge clk); #1;
      clear_obs();
      bus.tx_data  = d;
      bus.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      check("busy_after_accept", bus.busy, 1);
      if (mode == 1) begin
         repeat (40) @(posedge clk);
         #1;
         check("ready_low_busy", bus.tx_ready, 0);
         bus.tx_data  = 8'h3C;
         bus.tx_valid = 1'b1;
         @(posedge clk); #1;
         bus.tx_valid = 1'b0;
      end
      if (mode == 2) begin
         wait_for(2, 4, 400, "reach_rise4");
         div_stall = 1'b1;
         s_sclk = sclk; s_cs = cs_n; s_mosi = mosi;
         repeat (100) @(posedge clk);
         #1;
         check("stall_pins", {sclk, cs_n, mosi, bus.busy}, {s_sclk, s_cs, s_mosi, 1'b1});
         div_stall = 1'b0;
      end
      wait_for(0, 0, 800, "frame_done");
      exp_rx = RX_EN ? pack(miso_q, 0) : 8'h00;
      check("sclk_rises", rises, 8);
      check("mosi_bits", pack(mosi_q, 0), d);
      check("rx_valid_cnt", rxv_cnt, 1);
      check("rx_data", bus.rx_data, exp_rx);
      if (mode == 2) check("cs_low_stall", (cs_low >= 273 && cs_low <= 400), 1);
      else           check("cs_low_18ticks", (cs_low >= 273 && cs_low <= 288), 1);
      if (mode == 1) begin
         repeat (80) @(posedge clk);
         #1;
         check("no_queued_frame", {rises, 31'(bus.busy)}, {32'd8, 31'd0});
      end
   endtask

   initial begin
      logic [7:0] d;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_pins", {cs_n, sclk, mosi}, 3'b100);
      check("rst_hs", {bus.tx_ready, bus.busy, bus.rx_valid}, 3'b100);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check("idle_after_5ticks", {cs_n, sclk, bus.tx_ready, bus.busy}, 4'b1010);
      check("idle_no_rises", rises, 0);

      // 0xA5 loopback, then competing request while busy
      run_frame(8'hA5, 0, 0);
      run_frame(8'hA5, 0, 1);

      // Reset after the 3rd rising SCLK edge
      @(posedge clk); #1;
      clear_obs();
      miso_sel = 0;
      bus.tx_data  = 8'hC3;
      bus.tx_valid = 1'b1;
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
      wait_for(2, 3, 400, "reach_rise3");
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_pins", {cs_n, sclk, mosi}, 3'b100);
      check("midrst_busy", bus.busy, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("midrst_no_rxv", rxv_cnt, 0);
      check("midrst_rxdata", bus.rx_data, 0);
      run_frame(8'h0F, 0, 0);

      // MISO tied high, all-zero transmit
      run_frame(8'h00, 2, 0);

      // Divider stall mid-frame
      run_frame(8'h5A, 1, 2);

      // Random frames, loopback or random MISO
      for (int n = 0; n < 6; n++) begin
         d = 8'($urandom);
         run_frame(d, int'($urandom_range(0, 1)), 0);
      end

      // tx_valid held across two frames
      @(posedge clk); #1;
      clear_obs();
      miso_sel = 0;
      bus.tx_data  = 8'h81;
      bus.tx_valid = 1'b1;
      wait_for(1, 0, 50, "b2b_accept1");
      bus.tx_data = 8'h7E;
      wait_for(1, 1, 800, "b2b_idle");
      wait_for(1, 0, 50, "b2b_accept2");
      bus.tx_valid = 1'b0;
      wait_for(0, 0, 800, "b2b_done");
      check("b2b_rises", rises, 16);
      check("b2b_mosi0", pack(mosi_q, 0), 8'h81);
      check("b2b_mosi1", pack(mosi_q, 8), 8'h7E);
      check("b2b_rxv", rx_log.size(), 2);
      if (rx_log.size() == 2) begin
         check("b2b_rx0", rx_log[0], RX_EN ? 8'h81 : 8'h00);
         check("b2b_rx1", rx_log[1], RX_EN ? 8'h7E : 8'h00);
      end
      check("b2b_gap", (last_gap >= 17), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
